// File: rtl/sprite_frame_scheduler_if.sv
// Bundle of the scheduler's frame, sprite-engine and VGA-adapter signals.
// master: the scheduler (samples the sprite table, drives engine start and
//         adapter writes).
// slave:  the surrounding system (sprite table, sprite engine, adapter).
// Signals:
//   frame_tick, sprite_x/y/active      frame request and sprite table
//   eng_start, eng_x, eng_y            engine command (anchor of one sprite)
//   eng_pix_x/y/valid, eng_done        engine pixel stream and completion
//   vga_x, vga_y, vga_colour, vga_plot adapter write port
//   busy, frame_done, overrun          sequencer status
interface sprite_frame_scheduler_if #(
    parameter int NUM_SPRITES = 2
);
    logic                     frame_tick;
    logic [8*NUM_SPRITES-1:0] sprite_x;
    logic [7*NUM_SPRITES-1:0] sprite_y;
    logic [NUM_SPRITES-1:0]   sprite_active;

    logic                     eng_start;
    logic [7:0]               eng_x;
    logic [6:0]               eng_y;
    logic [7:0]               eng_pix_x;
    logic [6:0]               eng_pix_y;
    logic                     eng_pix_valid;
    logic                     eng_done;

    logic [7:0]               vga_x;
    logic [6:0]               vga_y;
    logic [2:0]               vga_colour;
    logic                     vga_plot;

    logic                     busy;
    logic                     frame_done;
    logic                     overrun;

    modport master (
        input  frame_tick, sprite_x, sprite_y, sprite_active,
        input  eng_pix_x, eng_pix_y, eng_pix_valid, eng_done,
        output eng_start, eng_x, eng_y,
        output vga_x, vga_y, vga_colour, vga_plot,
        output busy, frame_done, overrun
    );

    modport slave (
        output frame_tick, sprite_x, sprite_y, sprite_active,
        output eng_pix_x, eng_pix_y, eng_pix_valid, eng_done,
        input  eng_start, eng_x, eng_y,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  busy, frame_done, overrun
    );
endinterface

// File: rtl/sprite_frame_scheduler.sv
// Per-frame sequencer for a shared sprite pixel engine and a single 160x120
// 3-bit VGA adapter write port. Each frame tick: erase every previously drawn
// sprite (redraw in BG_COLOUR), draw every active sprite at its freshly
// latched position (FG_COLOUR), then commit the new positions as the old set.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    sprite_frame_scheduler_if.master (frame request, sprite table,
//          engine handshake, adapter write port, status)
module sprite_frame_scheduler #(
    parameter int         NUM_SPRITES = 2,
    parameter logic [2:0] FG_COLOUR   = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input logic                      clock,
    input logic                      reset,
    sprite_frame_scheduler_if.master bus
);

    localparam int                IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ERASE_START,
        ERASE_WAIT,
        DRAW_START,
        DRAW_WAIT,
        COMMIT
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       nxt_idx;
    logic                   last_slot;

    logic [7:0]             new_x [NUM_SPRITES];
    logic [6:0]             new_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] new_active;
    logic [7:0]             old_x [NUM_SPRITES];
    logic [6:0]             old_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] old_valid;

    logic                   eng_start_r;
    logic [7:0]             eng_x_r;
    logic [6:0]             eng_y_r;
    logic                   busy_r;
    logic                   frame_done_r;

    logic                   erase_advance;
    logic                   draw_advance;
    logic                   in_wait;
    logic                   pix_in_range;
    logic [2:0]             phase_colour;

    logic [7:0]             pix_x_p1;
    logic [6:0]             pix_y_p1;
    logic [2:0]             colour_p1;
    logic                   vld_p1;

    assign nxt_idx   = idx + IDX_W'(1);
    assign last_slot = (idx == LAST_IDX);

    // A slot is finished either by skipping it (nothing to draw) or by the
    // engine reporting completion while we wait on it.
    always_comb begin
        erase_advance = 1'b0;
        draw_advance  = 1'b0;
        in_wait       = 1'b0;
        phase_colour  = 3'b000;
        case (state)
            ERASE_START: erase_advance = ~old_valid[idx];
            ERASE_WAIT: begin
                erase_advance = bus.eng_done;
                in_wait       = 1'b1;
                phase_colour  = BG_COLOUR;
            end
            DRAW_START:  draw_advance = ~new_active[idx];
            DRAW_WAIT: begin
                draw_advance = bus.eng_done;
                in_wait      = 1'b1;
                phase_colour = FG_COLOUR;
            end
            default: ;
        endcase
        pix_in_range = (bus.eng_pix_x < 8'd160) && (bus.eng_pix_y < 7'd120);
    end

    // eng_start/eng_x/eng_y are loaded on entry to a *_START state for the slot
    // being entered, so the pulse coincides exactly with the START state and
    // is never visible in a *_WAIT state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            eng_start_r  <= 1'b0;
            eng_x_r      <= '0;
            eng_y_r      <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            new_active   <= '0;
            old_valid    <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                new_x[i] <= '0;
                new_y[i] <= '0;
                old_x[i] <= '0;
                old_y[i] <= '0;
            end
        end else begin
            eng_start_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        state  <= LATCH;
                        busy_r <= 1'b1;
                    end
                end
                LATCH: begin
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        new_x[i] <= bus.sprite_x[8*i +: 8];
                        new_y[i] <= bus.sprite_y[7*i +: 7];
                    end
                    new_active  <= bus.sprite_active;
                    idx         <= '0;
                    state       <= ERASE_START;
                    eng_start_r <= old_valid[0];
                    eng_x_r     <= old_x[0];
                    eng_y_r     <= old_y[0];
                end
                ERASE_START, ERASE_WAIT: begin
                    if (erase_advance) begin
                        if (last_slot) begin
                            idx         <= '0;
                            state       <= DRAW_START;
                            eng_start_r <= new_active[0];
                            eng_x_r     <= new_x[0];
                            eng_y_r     <= new_y[0];
                        end else begin
                            idx         <= nxt_idx;
                            state       <= ERASE_START;
                            eng_start_r <= old_valid[nxt_idx];
                            eng_x_r     <= old_x[nxt_idx];
                            eng_y_r     <= old_y[nxt_idx];
                        end
                    end else if (state == ERASE_START) begin
                        state <= ERASE_WAIT;
                    end
                end
                DRAW_START, DRAW_WAIT: begin
                    if (draw_advance) begin
                        if (last_slot) begin
                            idx          <= '0;
                            state        <= COMMIT;
                            frame_done_r <= 1'b1;
                        end else begin
                            idx         <= nxt_idx;
                            state       <= DRAW_START;
                            eng_start_r <= new_active[nxt_idx];
                            eng_x_r     <= new_x[nxt_idx];
                            eng_y_r     <= new_y[nxt_idx];
                        end
                    end else if (state == DRAW_START) begin
                        state <= DRAW_WAIT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        old_x[i] <= new_x[i];
                        old_y[i] <= new_y[i];
                    end
                    old_valid <= new_active;
                    state     <= IDLE;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p0 -> p1: clip engine pixel and register adapter write ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            pix_x_p1  <= '0;
            pix_y_p1  <= '0;
            colour_p1 <= '0;
        end else begin
            vld_p1    <= bus.eng_pix_valid & in_wait & pix_in_range;
            pix_x_p1  <= bus.eng_pix_x;
            pix_y_p1  <= bus.eng_pix_y;
            colour_p1 <= phase_colour;
        end
    end

    assign bus.eng_start  = eng_start_r;
    assign bus.eng_x      = eng_x_r;
    assign bus.eng_y      = eng_y_r;
    assign bus.vga_x      = pix_x_p1;
    assign bus.vga_y      = pix_y_p1;
    assign bus.vga_colour = colour_p1;
    assign bus.vga_plot   = vld_p1;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
    // busy_r mirrors "state != IDLE", so a tick is dropped in the same cycle.
    assign bus.overrun    = bus.frame_tick & busy_r;

endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
- Per-frame sequencer for the shared sprite pixel engine and the single VGA adapter write port (160x120, 3-bit colour).
- On each frame tick it does three things in order:
  - erases every sprite at its previous position by redrawing it in the background colour;
  - draws every active sprite at its newly latched position;
  - commits the new positions as the "old" set for the next frame.
- The engine is driven through a start/done handshake. Engine pixels are clipped, registered and forwarded to the adapter with the colour for the current phase.

Parameters:
- NUM_SPRITES, 2, number of sprite slots (1..8).
- FG_COLOUR, 3'b111, draw-phase colour.
- BG_COLOUR, 3'b000, erase-phase colour.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame
- sprite_x  in  8*NUM_SPRITES  anchor x per slot; slot i = bits [8i+7:8i]
- sprite_y  in  7*NUM_SPRITES  anchor y per slot; slot i = bits [7i+6:7i]
- sprite_active  in  NUM_SPRITES  slot i is drawn this frame
- eng_start  out  1  one-cycle start pulse to the sprite engine
- eng_x  out  8  anchor x to the engine, held from start until done
- eng_y  out  7  anchor y to the engine, held from start until done
- eng_pix_x  in  8  engine pixel x
- eng_pix_y  in  7  engine pixel y
- eng_pix_valid  in  1  engine pixel valid
- eng_done  in  1  engine finished the current sprite (one-cycle pulse)
- vga_x  out  8  adapter x
- vga_y  out  7  adapter y
- vga_colour  out  3  adapter colour
- vga_plot  out  1  adapter write enable
- busy  out  1  high whenever the state is not IDLE
- frame_done  out  1  one-cycle pulse when a frame's sequence completes
- overrun  out  1  one-cycle pulse when a frame_tick is dropped

Behaviour:
- States: IDLE, LATCH, ERASE_START, ERASE_WAIT, DRAW_START, DRAW_WAIT, COMMIT. Slot index idx counts 0..NUM_SPRITES-1.
- Reset:
  - state=IDLE, idx=0; all outputs 0.
  - new/old position and valid registers cleared.
  - Reset mid-frame abandons the sequence immediately. Pixels already written to frame memory are not cleaned up.
- IDLE: on frame_tick -> LATCH.
- LATCH (1 cycle):
  - snapshot sprite_x, sprite_y, sprite_active into new_* registers; idx=0;
  - -> ERASE_START.
- ERASE_START:
  - if old_valid[idx]: eng_start=1 with eng_x/eng_y = old position; -> ERASE_WAIT.
  - otherwise skip the slot (1 cycle, idx++).
  - After the last slot: idx=0 -> DRAW_START.
- ERASE_WAIT: pixel phase colour = BG_COLOUR. On eng_done: idx++, -> ERASE_START, or DRAW_START with idx=0 after the last slot.
- DRAW_START / DRAW_WAIT: same as the erase pair, but using new_active, new positions and FG_COLOUR. After the last slot -> COMMIT.
- COMMIT (1 cycle):
  - old_* <= new_*;
  - frame_done=1;
  - -> IDLE.
- eng_done is ignored outside the *_WAIT states. eng_start is never asserted in any *_WAIT state.
- Pixel path, 1-cycle registered latency:
  - vga_plot <= eng_pix_valid & in a *_WAIT state & eng_pix_x<160 & eng_pix_y<120.
  - vga_x/vga_y <= eng_pix_x/eng_pix_y.
  - vga_colour <= phase colour.
  - Out-of-range pixels (e.g. anchor-minus-offset underflow wrapping to x>=160) are dropped.
  - A pixel arriving in the same cycle as eng_done is still plotted.
- Overrun:
  - frame_tick while busy: overrun=1 for that cycle, tick discarded, sequence continues unaffected.
  - frame_tick in the COMMIT cycle also counts as overrun.
- Erase-before-draw guarantees no trail. Inputs are sampled only in LATCH, so they may change freely at any other time.
- busy is high from LATCH through COMMIT inclusive.

Test Plan:
- After reset, frame_tick with slot0 active at (20,30) and slot1 inactive:
  - no erase starts; exactly one eng_start with eng_x=20, eng_y=30;
  - each engine pixel appears on vga_* one cycle later with colour 3'b111;
  - frame_done pulses one cycle after eng_done.
- Second frame_tick with slot0 moved to (21,30):
  - first eng_start carries (20,30) and pixels are coloured 3'b000;
  - second eng_start carries (21,30) and pixels are coloured 3'b111.
- Engine returns pixel x=255 (wrap) and pixel y=125 -> vga_plot stays 0 for both; in-range pixels from the same sprite are still plotted.
- frame_tick asserted during DRAW_WAIT -> overrun pulses for 1 cycle; a single frame_done follows; no extra sequence starts.
- Reset asserted during ERASE_WAIT:
  - next cycle state=IDLE and all outputs 0;
  - the following frame_tick issues no erase starts (old_valid cleared).
- Both slots active, eng_done arriving in the same cycle as a valid pixel -> that pixel is plotted and the next slot's eng_start follows on a later cycle.
